// File: rtl/fpu_req_arbiter_if.sv
// Bundle of requester, response and FPU channels for the two-port FPU arbiter.
// The slave modport is the arbiter's view; master is the view of the logic
// driving the requesters and the FPU (e.g. a testbench or the surrounding SoC).
interface fpu_req_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Requester issue channels
    logic               req0_valid_i;
    logic               req1_valid_i;
    logic               req0_ready_o;
    logic               req1_ready_o;
    logic [3*WIDTH-1:0] req0_operands_i;
    logic [3*WIDTH-1:0] req1_operands_i;

    // Requester response channels (result bus shared)
    logic               rsp0_valid_o;
    logic               rsp1_valid_o;
    logic               rsp0_ready_i;
    logic               rsp1_ready_i;
    logic [WIDTH-1:0]   rsp_result_o;

    // FPU issue channel
    logic [3*WIDTH-1:0] fpu_operands_o;
    logic               fpu_in_valid_o;
    logic               fpu_in_ready_i;

    // FPU result channel
    logic [WIDTH-1:0]   fpu_result_i;
    logic               fpu_out_valid_i;
    logic               fpu_out_ready_o;

    // Status
    logic [CNT_W-1:0]   inflight_o;

    modport slave (
        input  req0_valid_i, req1_valid_i, req0_operands_i, req1_operands_i,
        input  rsp0_ready_i, rsp1_ready_i,
        input  fpu_in_ready_i, fpu_result_i, fpu_out_valid_i,
        output req0_ready_o, req1_ready_o,
        output rsp0_valid_o, rsp1_valid_o, rsp_result_o,
        output fpu_operands_o, fpu_in_valid_o, fpu_out_ready_o,
        output inflight_o
    );

    modport master (
        output req0_valid_i, req1_valid_i, req0_operands_i, req1_operands_i,
        output rsp0_ready_i, rsp1_ready_i,
        output fpu_in_ready_i, fpu_result_i, fpu_out_valid_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp0_valid_o, rsp1_valid_o, rsp_result_o,
        input  fpu_operands_o, fpu_in_valid_o, fpu_out_ready_o,
        input  inflight_o
    );
endinterface

// File: rtl/fpu_req_arbiter.sv
// Two-requester round-robin arbiter in front of a single in-order FPU.
// Issue is zero-latency (operands pass straight through); the requester ID of
// each issued operation is queued so results can be steered back in order.
module fpu_req_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input logic             clk_i,
    input logic             rst_ni,
    fpu_req_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic               rr;          // preferred requester
    logic               lock;        // issue stalled, grant frozen
    logic               lock_id;     // requester holding the stalled grant
    logic               grant;
    logic [1:0]         req_valid;
    logic [3*WIDTH-1:0] sel_ops;

    logic [DEPTH-1:0]   id_mem;      // one requester ID per in-flight op
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   inflight;

    logic               not_full;
    logic               not_empty;
    logic               in_valid;
    logic               issue;
    logic               head;
    logic               out_ready;
    logic               retire;

    assign req_valid = {bus.req1_valid_i, bus.req0_valid_i};

    // Grant selection: a stalled grant is frozen, otherwise prefer rr and fall back to the other
    always_comb begin
        grant = rr;
        if (lock) begin
            grant = lock_id;
        end else if (req_valid[rr]) begin
            grant = rr;
        end else if (req_valid[~rr]) begin
            grant = ~rr;
        end
    end

    // Issue side: operands pass through untouched; full FIFO blocks issue.
    // rst_ni gating keeps the handshake quiet while reset is held.
    assign sel_ops   = grant ? bus.req1_operands_i : bus.req0_operands_i;
    assign not_full  = (inflight < CNT_W'(DEPTH));
    assign in_valid  = rst_ni & req_valid[grant] & not_full;
    assign issue     = in_valid & bus.fpu_in_ready_i;

    assign bus.fpu_operands_o = sel_ops;
    assign bus.fpu_in_valid_o = in_valid;
    assign bus.req0_ready_o   = issue & ~grant;
    assign bus.req1_ready_o   = issue & grant;

    // Result side: only the requester at the FIFO head sees the result.
    // With nothing in flight, stray FPU results are not accepted.
    assign not_empty = (inflight != '0);
    assign head      = id_mem[rd_ptr];
    assign out_ready = not_empty & (head ? bus.rsp1_ready_i : bus.rsp0_ready_i);
    assign retire    = bus.fpu_out_valid_i & out_ready;

    assign bus.rsp0_valid_o    = not_empty & bus.fpu_out_valid_i & ~head;
    assign bus.rsp1_valid_o    = not_empty & bus.fpu_out_valid_i & head;
    assign bus.rsp_result_o    = bus.fpu_result_i;
    assign bus.fpu_out_ready_o = out_ready;
    assign bus.inflight_o      = inflight;

    // Control state: round-robin pointer, stall lock, FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr       <= 1'b0;
            lock     <= 1'b0;
            lock_id  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= '0;
        end else begin
            // Lock holds only while the granted request waits on the FPU
            lock <= in_valid & ~bus.fpu_in_ready_i;
            if (in_valid & ~bus.fpu_in_ready_i) begin
                lock_id <= grant;
            end
            if (issue) begin
                rr     <= ~grant;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (retire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({issue, retire})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // ID storage: record the issuing requester; contents are meaningless when empty
    always_ff @(posedge clk_i) begin
        if (issue) begin
            id_mem[wr_ptr] <= grant;
        end
    end
endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Testbench for fpu_req_arbiter: cycle tables for arbitration, a scoreboard
// of expected requester IDs/results, and hand sequences for full, hold and reset.
module tb_fpu_req_arbiter;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fpu_req_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fpu_req_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic               v0, v1, rdy;
        logic [3*WIDTH-1:0] ops0, ops1;
        logic               e_inv, e_r0, e_r1, e_gid;
        logic [CNT_W-1:0]   e_infl;
        logic [WIDTH-1:0]   res;
    } vec_t;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] res;
    } exp_t;

    exp_t sb[$];
    vec_t tab1[5];
    vec_t tab2[6];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid_i    = 1'b0;
        bus.req1_valid_i    = 1'b0;
        bus.fpu_in_ready_i  = 1'b0;
        bus.fpu_out_valid_i = 1'b0;
        bus.rsp0_ready_i    = 1'b1;
        bus.rsp1_ready_i    = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        @(negedge clk);
        bus.req0_valid_i    = v.v0;
        bus.req1_valid_i    = v.v1;
        bus.req0_operands_i = v.ops0;
        bus.req1_operands_i = v.ops1;
        bus.fpu_in_ready_i  = v.rdy;
        bus.fpu_out_valid_i = 1'b0;
        #1;
        check({tag, "_in_valid"}, 128'(bus.fpu_in_valid_o), 128'(v.e_inv));
        check({tag, "_ready0"},   128'(bus.req0_ready_o),   128'(v.e_r0));
        check({tag, "_ready1"},   128'(bus.req1_ready_o),   128'(v.e_r1));
        check({tag, "_operands"}, 128'(bus.fpu_operands_o), 128'(v.e_gid ? v.ops1 : v.ops0));
        check({tag, "_inflight"}, 128'(bus.inflight_o),     128'(v.e_infl));
        if (v.e_inv && v.rdy) sb.push_back('{id: v.e_gid, res: v.res});
    endtask

    task automatic drain_one(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 128'(1), 128'(0));
            return;
        end
        e = sb.pop_front();
        @(negedge clk);
        bus.req0_valid_i    = 1'b0;
        bus.req1_valid_i    = 1'b0;
        bus.rsp0_ready_i    = 1'b1;
        bus.rsp1_ready_i    = 1'b1;
        bus.fpu_out_valid_i = 1'b1;
        bus.fpu_result_i    = e.res;
        #1;
        check({tag, "_rsp0_valid"}, 128'(bus.rsp0_valid_o),    128'(e.id == 1'b0));
        check({tag, "_rsp1_valid"}, 128'(bus.rsp1_valid_o),    128'(e.id == 1'b1));
        check({tag, "_result"},     128'(bus.rsp_result_o),    128'(e.res));
        check({tag, "_out_ready"},  128'(bus.fpu_out_ready_o), 128'(1));
    endtask

    initial begin
        logic [3*WIDTH-1:0] a0, a1, b0, b1, fma1;
        a0   = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
        a1   = {32'h0000_0013, 32'h0000_0012, 32'h0000_0011};
        b0   = {32'h0000_0023, 32'h0000_0022, 32'h0000_0021};
        b1   = {32'h0000_0033, 32'h0000_0032, 32'h0000_0031};
        fma1 = {32'h0000_0000, 32'h4000_0000, 32'h3F80_0000};

        // Both requesting, FPU always ready: alternate 0,1,0,1 then full
        //           v0 v1 rdy ops0 ops1 inv r0 r1 gid infl res
        tab1[0] = '{1, 1, 1, a0, a1, 1, 1, 0, 0, 0, 32'h1111_0000};
        tab1[1] = '{1, 1, 1, a0, a1, 1, 0, 1, 1, 1, 32'h1111_0001};
        tab1[2] = '{1, 1, 1, a0, a1, 1, 1, 0, 0, 2, 32'h1111_0002};
        tab1[3] = '{1, 1, 1, a0, a1, 1, 0, 1, 1, 3, 32'h1111_0003};
        tab1[4] = '{1, 1, 1, a0, a1, 0, 0, 0, 0, 4, 32'h1111_0004};

        // Stalled req0 keeps the grant while req1 arrives (rr points at 1 here)
        tab2[0] = '{1, 0, 0, b0, b1,   1, 0, 0, 0, 0, 32'h2222_0000};
        tab2[1] = '{1, 1, 0, b0, b1,   1, 0, 0, 0, 0, 32'h2222_0001};
        tab2[2] = '{1, 1, 0, b0, b1,   1, 0, 0, 0, 0, 32'h2222_0002};
        tab2[3] = '{1, 1, 1, b0, b1,   1, 1, 0, 0, 0, 32'h2222_0003};
        tab2[4] = '{0, 1, 1, b0, b1,   1, 0, 1, 1, 1, 32'h2222_0004};
        tab2[5] = '{0, 1, 1, b0, fma1, 1, 0, 1, 1, 2, 32'h4000_0000};

        // Reset with requests and a result pending: everything must stay quiet
        rst_n = 1'b0;
        idle_inputs();
        bus.req0_valid_i    = 1'b1;
        bus.req1_valid_i    = 1'b1;
        bus.req0_operands_i = a0;
        bus.req1_operands_i = a1;
        bus.fpu_in_ready_i  = 1'b1;
        bus.fpu_out_valid_i = 1'b1;
        bus.fpu_result_i    = 32'hDEAD_BEEF;
        #2;
        check("rst_inflight",  128'(bus.inflight_o),      128'(0));
        check("rst_in_valid",  128'(bus.fpu_in_valid_o),  128'(0));
        check("rst_ready0",    128'(bus.req0_ready_o),    128'(0));
        check("rst_ready1",    128'(bus.req1_ready_o),    128'(0));
        check("rst_rsp0",      128'(bus.rsp0_valid_o),    128'(0));
        check("rst_rsp1",      128'(bus.rsp1_valid_o),    128'(0));
        check("rst_out_ready", 128'(bus.fpu_out_ready_o), 128'(0));
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) apply_vec(tab1[i], $sformatf("rr%0d", i));

        // Full FIFO with a same-cycle retire: no issue now, issue next cycle
        @(negedge clk);
        bus.req0_valid_i    = 1'b1;
        bus.req1_valid_i    = 1'b0;
        bus.fpu_in_ready_i  = 1'b1;
        bus.fpu_out_valid_i = 1'b1;
        bus.fpu_result_i    = sb[0].res;
        #1;
        check("full_in_valid",  128'(bus.fpu_in_valid_o),  128'(0));
        check("full_ready0",    128'(bus.req0_ready_o),    128'(0));
        check("full_out_ready", 128'(bus.fpu_out_ready_o), 128'(1));
        check("full_rsp0",      128'(bus.rsp0_valid_o),    128'(sb[0].id == 1'b0));
        check("full_rsp1",      128'(bus.rsp1_valid_o),    128'(sb[0].id == 1'b1));
        void'(sb.pop_front());
        @(negedge clk);
        bus.fpu_out_valid_i = 1'b0;
        #1;
        check("refill_inflight", 128'(bus.inflight_o),     128'(3));
        check("refill_in_valid", 128'(bus.fpu_in_valid_o), 128'(1));
        check("refill_ready0",   128'(bus.req0_ready_o),   128'(1));
        sb.push_back('{id: 1'b0, res: 32'h1111_0005});
        @(negedge clk);
        bus.req0_valid_i = 1'b0;
        #1;
        check("refull_inflight", 128'(bus.inflight_o), 128'(4));

        // Head result for requester 1 goes straight through
        drain_one("drain1_0");

        // Head owner (requester 0) not ready: result held, FIFO not popped
        @(negedge clk);
        bus.rsp0_ready_i    = 1'b0;
        bus.rsp1_ready_i    = 1'b1;
        bus.fpu_out_valid_i = 1'b1;
        bus.fpu_result_i    = sb[0].res;
        #1;
        check("hold_out_ready", 128'(bus.fpu_out_ready_o), 128'(0));
        check("hold_rsp0",      128'(bus.rsp0_valid_o),    128'(sb[0].id == 1'b0));
        check("hold_rsp1",      128'(bus.rsp1_valid_o),    128'(sb[0].id == 1'b1));
        @(negedge clk);
        #1;
        check("hold_inflight",   128'(bus.inflight_o),      128'(3));
        check("hold_out_ready2", 128'(bus.fpu_out_ready_o), 128'(0));
        for (int i = 0; i < 3; i++) drain_one($sformatf("drain1_%0d", i + 1));
        @(negedge clk);
        idle_inputs();
        #1;
        check("drain1_inflight", 128'(bus.inflight_o),      128'(0));
        check("drain1_idle_rdy", 128'(bus.fpu_out_ready_o), 128'(0));

        for (int i = 0; i < 6; i++) apply_vec(tab2[i], $sformatf("lock%0d", i));
        for (int i = 0; i < 3; i++) drain_one($sformatf("drain2_%0d", i));
        @(negedge clk);
        idle_inputs();
        #1;
        check("drain2_inflight", 128'(bus.inflight_o), 128'(0));

        // Reset mid-operation with three in flight, then a late FPU result
        bus.req0_valid_i   = 1'b1;
        bus.fpu_in_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        bus.req1_valid_i    = 1'b1;
        bus.fpu_out_valid_i = 1'b0;
        #1;
        check("mid_inflight", 128'(bus.inflight_o), 128'(3));
        bus.fpu_out_valid_i = 1'b1;
        bus.fpu_result_i    = 32'hBAD0_0001;
        bus.rsp0_ready_i    = 1'b1;
        bus.rsp1_ready_i    = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_inflight",  128'(bus.inflight_o),      128'(0));
        check("mid_rst_in_valid",  128'(bus.fpu_in_valid_o),  128'(0));
        check("mid_rst_ready0",    128'(bus.req0_ready_o),    128'(0));
        check("mid_rst_ready1",    128'(bus.req1_ready_o),    128'(0));
        check("mid_rst_rsp0",      128'(bus.rsp0_valid_o),    128'(0));
        check("mid_rst_rsp1",      128'(bus.rsp1_valid_o),    128'(0));
        check("mid_rst_out_ready", 128'(bus.fpu_out_ready_o), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        #1;
        check("late_rsp0",      128'(bus.rsp0_valid_o),    128'(0));
        check("late_rsp1",      128'(bus.rsp1_valid_o),    128'(0));
        check("late_out_ready", 128'(bus.fpu_out_ready_o), 128'(0));
        @(negedge clk);
        #1;
        check("late_inflight", 128'(bus.inflight_o), 128'(0));
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
